// File: rtl/knn_sorted_list.sv
// knn_sorted_list: K-entry insertion-sorted (distance, label) list with valid/ready streaming readout
module knn_sorted_list #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 4,
  parameter int CNT_W   = $clog2(K + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_dist,
  input  logic [LABEL_W-1:0]        in_label,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+LABEL_W-1:0] out_data,
  output logic                      out_last,
  output logic [CNT_W-1:0]          count,
  output logic                      done
);
  localparam int IDX_W = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_dist  [K];
  logic [LABEL_W-1:0]  r_label [K];
  logic [K-1:0]        r_occ, w_lt;
  logic [CNT_W-1:0]    r_count;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_done, w_done_nxt, w_ins, w_hs, w_last;
  // Unoccupied slots behave as +infinity; strict compare places ties after existing entries
  for (genvar i = 0; i < K; i++) begin : g_lt
    assign w_lt[i] = !r_occ[i] || (in_dist < r_dist[i]);
  end
  assign in_ready  = r_state == RUN;
  assign out_valid = r_state == OUT;
  assign w_ins     = in_valid && in_ready && |w_lt;
  assign w_hs      = out_valid && out_ready;
  assign w_last    = CNT_W'(r_ptr) == r_count - CNT_W'(1);
  assign out_last  = out_valid && w_last;
  assign out_data  = {r_dist[r_ptr], r_label[r_ptr]};
  assign count     = r_count;
  assign done      = r_done;
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (start)
      w_state_nxt = RUN;
    else if (r_state == RUN && stop) begin
      w_done_nxt  = r_count == '0 && !w_ins;
      w_state_nxt = w_done_nxt ? IDLE : OUT;
    end else if (w_hs && w_last) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_occ   <= '0;
      r_count <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < K; i++) begin
        r_dist[i]  <= '0;
        r_label[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (start) begin
        r_occ   <= '0;
        r_count <= '0;
        r_ptr   <= '0;
      end else begin
        if (w_ins) begin
          if (w_lt[0]) begin
            r_dist[0]  <= in_dist;
            r_label[0] <= in_label;
            r_occ[0]   <= 1'b1;
          end
          // A slot below the insertion point inherits its upper neighbour
          for (int i = 1; i < K; i++)
            if (w_lt[i]) begin
              r_dist[i]  <= w_lt[i-1] ? r_dist[i-1]  : in_dist;
              r_label[i] <= w_lt[i-1] ? r_label[i-1] : in_label;
              r_occ[i]   <= w_lt[i-1] ? r_occ[i-1]   : 1'b1;
            end
          r_count <= r_count + CNT_W'(r_count != CNT_W'(K));
        end
        if (w_hs && !w_last)
          r_ptr <= r_ptr + IDX_W'(1);
      end
    end
  end
endmodule

// File: doc/knn_sorted_list.md
# knn_sorted_list

Parametrised K-entry insertion-sorted neighbour list for the KNN accelerator. It replaces hand-chained single-slot list elements with one block of depth `K`. The block accepts a stream of (distance, label) candidates and keeps the `K` smallest distances in ascending order. On command it streams the sorted result out over a valid/ready handshake. It sits between the distance-computation datapath and the label-voting stage.

## Interface
Parameters:
- `DATA_W`, 32, distance width; distances compare as unsigned.
- `LABEL_W`, 8, label width.
- `K`, 4, list depth, 1..64.
- `CNT_W`, $clog2(K+1), width of the entry count.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: clear list, enter RUN.
- `stop`  in  1  one-cycle pulse: end accumulation, enter OUT.
- `in_valid`  in  1  candidate present.
- `in_ready`  out  1  block accepts a candidate this cycle.
- `in_dist`  in  DATA_W  candidate distance.
- `in_label`  in  LABEL_W  candidate label.
- `out_valid`  out  1  sorted entry present.
- `out_ready`  in  1  consumer takes the entry.
- `out_data`  out  DATA_W+LABEL_W  {dist, label} of the current entry.
- `out_last`  out  1  current entry is the final one.
- `count`  out  CNT_W  number of occupied slots, 0..K.
- `done`  out  1  one-cycle pulse when the OUT phase completes.

## Operation
- Storage: `K` slots, slot 0 = smallest distance. Each slot holds {dist, label, occ}. An unoccupied slot compares as +infinity.
- FSM states: IDLE, RUN, OUT.
  - IDLE: `in_ready`=0, `out_valid`=0.
  - RUN: `in_ready`=1.
  - OUT: `in_ready`=0; entries stream out.
- Transitions:
  - `start` in any state -> RUN, clears all `occ` and `count`. `start` has priority over everything, including an OUT stream in progress; that stream is abandoned and `done` is not pulsed.
  - RUN + `stop` -> OUT. If `count`=0 the block instead goes -> IDLE and pulses `done`.
  - OUT + final handshake -> IDLE and pulses `done`.
  - `stop` outside RUN is ignored.
- Insertion on `in_valid & in_ready`, all slots updated in parallel in one cycle:
  - `lt[i]` = !occ[i] | (in_dist < dist[i]), strictly less.
  - `lt` is monotone. The insertion point `p` is the lowest `i` with `lt[i]`=1.
  - Slots i>p take slot i-1, shifting down. Slot p takes the candidate. Slot K-1's old content is discarded.
  - If no `lt[i]`=1 (list full, candidate >= all entries), the candidate is dropped and nothing changes.
- Ties: an equal distance is not inserted ahead of an existing entry. It goes after all equal entries, so among equal distances the earliest arrival ranks first. A tie with slot K-1 on a full list drops the candidate.
- `count` increments on each insertion while below `K` and saturates at `K`.
- Accept and `stop` in the same cycle: the candidate is inserted, then OUT starts with the updated list.
- OUT streaming:
  - Read pointer `ptr` starts at 0.
  - `out_data` = slot[ptr]; `out_last` = (ptr == count-1).
  - `ptr` advances on `out_valid & out_ready`.
  - The list is frozen during OUT and stays readable until the next `start`.

## Timing
- Reset values: FSM=IDLE; all `occ`, `count`, `ptr` = 0; `in_ready`, `out_valid`, `out_last`, `done` = 0; `out_data` = 0.
- Insertion latency: a candidate accepted at edge n is reflected in `count` and slot contents after edge n. A back-to-back accept at edge n+1 sees the updated list. Throughput is 1 candidate/cycle.
- `in_ready` rises the cycle after `start` is sampled and falls the cycle after `stop` is sampled.
- `out_valid` rises the cycle after `stop` is sampled. `out_data` and `out_last` stay stable while `out_valid & !out_ready`.
- `done` is asserted the cycle after the final handshake, or after `stop` when `count`=0.
- An asynchronous reset mid-stream returns the block to IDLE immediately. The list contents are lost.

## Test plan
- K=4, insert dists 50,20,80,10 -> stream out 10,20,50,80 with matching labels; `out_last` on 80; `done` pulses one cycle later.
- K=4, insert 9,7,5,3,1,8 -> `count` saturates at 4; stream 1,3,5,7. Then insert 10 -> dropped, list unchanged.
- Ties: insert (5,L=1),(5,L=2),(5,L=3) -> stream out labels 1,2,3 in that order.
- `stop` with no candidates -> `out_valid` stays 0, `done` pulses, state IDLE. `stop` asserted with `in_valid` (dist 4) on list {6} -> stream 4,6.
- Backpressure: hold `out_ready`=0 for 3 cycles mid-stream -> `out_data` stable; no entry skipped or duplicated.
- `start` during OUT after 2 of 4 entries -> `out_valid` drops next cycle, `count`=0, `in_ready`=1, no `done`. Drive `rst` low mid-RUN -> all outputs return to their reset values immediately.
